// File: rtl/word_memory_if.sv
// Request/response bus of word_memory: valid/ready request channel, one-cycle
// response pulse, and the clear-sequence status flag.
interface word_memory_if #(
  parameter int ADDR_W = 10,
  parameter int WIDTH  = 16
);
  logic                req_valid;
  logic                req_ready;
  logic                req_we;
  logic                req_dbl;
  logic [ADDR_W-1:0]   req_addr;
  logic [2*WIDTH-1:0]  req_wdata;
  logic                rsp_valid;
  logic [2*WIDTH-1:0]  rsp_rdata;
  logic                init_done;

  modport master (
    output req_valid, req_we, req_dbl, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, init_done
  );

  modport slave (
    input  req_valid, req_we, req_dbl, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, init_done
  );
endinterface

// File: rtl/word_memory.sv
// Single-port word memory with single/double-word accesses and a post-reset
// clear sequence that writes CLEAR_VAL to every location.
module word_memory #(
  parameter int               ADDR_W    = 10,
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] CLEAR_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  word_memory_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_BEAT2} state_e;

  state_e              r_state, w_state_next;
  logic [ADDR_W-1:0]   r_cnt;
  logic [ADDR_W-1:0]   r_dbl_addr;
  logic                r_dbl_we;
  logic [WIDTH-1:0]    r_dbl_whi;
  logic                r_rsp_valid;
  logic [2*WIDTH-1:0]  r_rsp_rdata;
  logic                r_init_done;
  logic [WIDTH-1:0]    r_mem [DEPTH];

  logic                w_accept;
  logic                w_mem_we;
  logic                w_mem_re;
  logic                w_rd_hi;
  logic [ADDR_W-1:0]   w_mem_addr;
  logic [WIDTH-1:0]    w_mem_wdata;

  assign w_accept      = bus.req_valid && (r_state == S_IDLE);
  assign bus.req_ready = (r_state == S_IDLE);
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.init_done = r_init_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_INIT;
    else      r_state <= w_state_next;
  end

  // The single array port is steered by state: clear counter, new request,
  // or the latched second beat of a double access.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    w_state_next = r_state;
    w_mem_we     = 1'b0;
    w_mem_re     = 1'b0;
    w_rd_hi      = 1'b0;
    w_mem_addr   = r_cnt;
    w_mem_wdata  = CLEAR_VAL;
    case (r_state)
      S_INIT: begin
        w_mem_we = 1'b1;
        if (r_cnt == ADDR_W'(DEPTH - 1)) w_state_next = S_IDLE;
      end
      S_IDLE: begin
        if (w_accept) begin
          w_mem_addr  = bus.req_addr;
          w_mem_wdata = bus.req_wdata[WIDTH-1:0];
          w_mem_we    = bus.req_we;
          w_mem_re    = !bus.req_we;
          if (bus.req_dbl) w_state_next = S_BEAT2;
        end
      end
      S_BEAT2: begin
        w_mem_addr   = r_dbl_addr + 1'b1;
        w_mem_wdata  = r_dbl_whi;
        w_mem_we     = r_dbl_we;
        w_mem_re     = !r_dbl_we;
        w_rd_hi      = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_INIT;
    endcase
  end

  // NOTE: the array has no reset; the INIT sequence clears it after every reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_addr] <= w_mem_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt       <= '0;
      r_dbl_addr  <= '0;
      r_dbl_we    <= 1'b0;
      r_dbl_whi   <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_init_done <= 1'b0;
    end else begin
      if (r_state == S_INIT) begin
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == ADDR_W'(DEPTH - 1)) r_init_done <= 1'b1;
      end
      if (w_accept && bus.req_dbl) begin
        r_dbl_addr <= bus.req_addr;
        r_dbl_we   <= bus.req_we;
        r_dbl_whi  <= bus.req_wdata[2*WIDTH-1:WIDTH];
      end
      r_rsp_valid <= (w_accept && !bus.req_dbl) || (r_state == S_BEAT2);
      // Writes leave the response data untouched.
      if (w_mem_re) begin
        if (w_rd_hi)
          r_rsp_rdata[2*WIDTH-1:WIDTH] <= r_mem[w_mem_addr];
        else if (bus.req_dbl)
          r_rsp_rdata[WIDTH-1:0] <= r_mem[w_mem_addr];
        else
          r_rsp_rdata <= {{WIDTH{1'b0}}, r_mem[w_mem_addr]};
      end
    end
  end
endmodule

// File: tb/tb_word_memory.sv
// Self-checking bench for word_memory (ADDR_W=4, WIDTH=16, CLEAR_VAL=A5A5)
// against an array-based reference model of the memory contents.
module tb_word_memory;
  localparam int          AW    = 4;
  localparam int          W     = 16;
  localparam int          DEPTH = 16;
  localparam logic [15:0] CLR   = 16'hA5A5;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [15:0] model_mem [DEPTH];
  logic [31:0] model_rdata;

  word_memory_if #(.ADDR_W(AW), .WIDTH(W)) bus ();

  word_memory #(.ADDR_W(AW), .WIDTH(W), .CLEAR_VAL(CLR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = CLR;
    model_rdata = 32'h0;
  endtask

  // Releases reset and checks the clear sequence lasts exactly DEPTH cycles.
  task automatic release_and_init(input string tag);
    rst = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      tick();
      check($sformatf("%s_done_c%0d", tag, i), 32'(bus.init_done), 32'(i == DEPTH));
      check($sformatf("%s_ready_c%0d", tag, i), 32'(bus.req_ready), 32'(i == DEPTH));
    end
    model_clear();
  endtask

  task automatic access(input string tag, input logic we, input logic dbl,
                        input logic [3:0] addr, input logic [31:0] wdata);
    int n;
    int a;
    int a1;
    n = 0;
    while (!bus.req_ready && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_ready_wait"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_dbl   = dbl;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    tick();
    bus.req_valid = 1'b0;
    bus.req_wdata = $urandom;
    a  = int'(addr);
    a1 = (a + 1) % DEPTH;
    if (we) begin
      model_mem[a] = wdata[15:0];
      if (dbl) model_mem[a1] = wdata[31:16];
    end else begin
      model_rdata = dbl ? {model_mem[a1], model_mem[a]} : {16'h0, model_mem[a]};
    end
    if (dbl) begin
      check({tag, "_beat2_ready"}, 32'(bus.req_ready), 32'd0);
      check({tag, "_beat2_rsp"}, 32'(bus.rsp_valid), 32'd0);
      tick();
    end
    check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
    check({tag, "_rdata"}, bus.rsp_rdata, model_rdata);
  endtask

  initial begin
    int acc;
    int rsp;
    logic [3:0] ra;
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_dbl   = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    #2 rst = 1'b0;
    #1;
    check("rst_ready", 32'(bus.req_ready), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rdata", bus.rsp_rdata, 32'h0);
    check("rst_init_done", 32'(bus.init_done), 32'd0);
    repeat (2) tick();
    release_and_init("init");

    for (int i = 0; i < DEPTH; i++) access($sformatf("clr_rd%0d", i), 1'b0, 1'b0, 4'(i), 32'h0);

    access("wr3", 1'b1, 1'b0, 4'd3, 32'hFFFF1234);
    access("rd3", 1'b0, 1'b0, 4'd3, 32'h0);
    check("rd3_const", bus.rsp_rdata, 32'h00001234);
    tick();
    check("rd3_pulse_end", 32'(bus.rsp_valid), 32'd0);

    access("dwr6", 1'b1, 1'b1, 4'd6, 32'hDEADBEEF);
    access("drd6", 1'b0, 1'b1, 4'd6, 32'h0);
    check("drd6_const", bus.rsp_rdata, 32'hDEADBEEF);
    access("rd6", 1'b0, 1'b0, 4'd6, 32'h0);
    check("rd6_const", bus.rsp_rdata, 32'h0000BEEF);
    access("rd7", 1'b0, 1'b0, 4'd7, 32'h0);
    check("rd7_const", bus.rsp_rdata, 32'h0000DEAD);

    access("dwr15", 1'b1, 1'b1, 4'd15, 32'h11112222);
    access("rd15", 1'b0, 1'b0, 4'd15, 32'h0);
    check("rd15_const", bus.rsp_rdata, 32'h00002222);
    access("rd0", 1'b0, 1'b0, 4'd0, 32'h0);
    check("rd0_const", bus.rsp_rdata, 32'h00001111);
    access("drd15", 1'b0, 1'b1, 4'd15, 32'h0);
    check("drd15_const", bus.rsp_rdata, 32'h11112222);

    for (int i = 0; i < 40; i++)
      access($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             4'($urandom_range(0, 15)), $urandom);

    // Held double-read requests: one acceptance every two cycles.
    ra = 4'($urandom_range(0, 15));
    acc = 0;
    rsp = 0;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_dbl   = 1'b1;
    bus.req_addr  = ra;
    for (int i = 0; i < 20; i++) begin
      if (bus.req_ready) acc++;
      tick();
      if (bus.rsp_valid) rsp++;
    end
    bus.req_valid = 1'b0;
    model_rdata = {model_mem[(int'(ra) + 1) % DEPTH], model_mem[ra]};
    check("dbl_stream_accepts", 32'(acc), 32'd10);
    check("dbl_stream_rsps", 32'(rsp), 32'd10);
    check("dbl_stream_rdata", bus.rsp_rdata, model_rdata);

    // Held single-read requests: one acceptance per cycle.
    acc = 0;
    rsp = 0;
    bus.req_valid = 1'b1;
    bus.req_dbl   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (bus.req_ready) acc++;
      tick();
      if (bus.rsp_valid) rsp++;
    end
    bus.req_valid = 1'b0;
    model_rdata = {16'h0, model_mem[ra]};
    check("sgl_stream_accepts", 32'(acc), 32'd8);
    check("sgl_stream_rsps", 32'(rsp), 32'd8);
    check("sgl_stream_rdata", bus.rsp_rdata, model_rdata);
    tick();
    check("sgl_stream_idle", 32'(bus.rsp_valid), 32'd0);

    // Reset during the second beat of a double write.
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_dbl   = 1'b1;
    bus.req_addr  = 4'd2;
    bus.req_wdata = 32'hCAFEF00D;
    tick();
    bus.req_valid = 1'b0;
    check("mid_beat2_ready", 32'(bus.req_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("mid_rst_ready", 32'(bus.req_ready), 32'd0);
    check("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("mid_rst_rdata", bus.rsp_rdata, 32'h0);
    check("mid_rst_init_done", 32'(bus.init_done), 32'd0);
    tick();
    check("mid_rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
    release_and_init("reinit");
    access("post_rd2", 1'b0, 1'b0, 4'd2, 32'h0);
    check("post_rd2_const", bus.rsp_rdata, 32'h0000A5A5);
    access("post_rd3", 1'b0, 1'b0, 4'd3, 32'h0);
    check("post_rd3_const", bus.rsp_rdata, 32'h0000A5A5);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/word_memory.md
# word_memory

Parametrised single-port word memory for the processor's instruction and data stores, with single- or double-word (2×WIDTH) accesses behind a valid/ready request handshake. Replaces file-loaded reset with a synthesizable clear sequence that writes CLEAR_VAL to every location after reset. The memory stage drives requests and consumes one registered response per accepted request; double accesses serve 32-bit stack pushes and pops such as PC save and restore.

## Interface
- ADDR_W, 10, address width; DEPTH = 2**ADDR_W words
- WIDTH, 16, word width in bits
- CLEAR_VAL, 0, value written to every word during INIT

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_we  in  1  1 = write, 0 = read
- req_dbl  in  1  1 = double-word access, 0 = single word
- req_addr  in  ADDR_W  word address (low word for double access)
- req_wdata  in  2*WIDTH  write data; single access uses [WIDTH-1:0]
- rsp_valid  out  1  one-cycle pulse, request completed
- rsp_rdata  out  2*WIDTH  read data; single read zero-extends into the upper half
- init_done  out  1  high once the clear sequence has finished

## Operation
- States: INIT, IDLE, BEAT2.
- INIT: writes CLEAR_VAL to address cnt, cnt increments once per cycle from 0. After writing DEPTH-1, the state moves to IDLE and init_done goes to 1. req_ready stays 0 throughout INIT.
- IDLE: req_ready = 1. A request is accepted on a rising edge when req_valid && req_ready.
  - Single write: mem[addr] <= wdata[WIDTH-1:0].
  - Single read: rsp_rdata <= {0, mem[addr]}.
  - Double access: the request is latched (we, addr, wdata). Beat 1 targets addr and writes wdata[WIDTH-1:0] or captures the read into rsp_rdata[WIDTH-1:0]. State moves to BEAT2.
- BEAT2: req_ready = 0. Beat 2 targets (addr+1) mod DEPTH and writes wdata[2*WIDTH-1:WIDTH] or captures the read into rsp_rdata[2*WIDTH-1:WIDTH]. State returns to IDLE.
- Word order is little-endian: the low word is at addr, the high word at addr+1. Address arithmetic is ADDR_W bits and wraps, so DEPTH-1 is followed by 0.
- rsp_valid pulses for reads and writes. On writes, rsp_rdata holds its previous value.
- Single port only, so no two array accesses can occur in the same cycle.
- A read issued in the cycle after a write to the same address returns the new data.

## Timing
- Reset values: state = INIT, cnt = 0, req_ready = 0, rsp_valid = 0, rsp_rdata = 0, init_done = 0. Array contents are not reset; they are cleared by INIT.
- After rst deasserts, INIT takes DEPTH cycles. The first acceptance is possible at the edge that ends cycle DEPTH+1.
- Single access accepted at edge E0: rsp_valid = 1 and rsp_rdata valid from E0 to E1. Back-to-back singles are accepted every cycle.
- Double access accepted at E0: state is BEAT2 from E0 to E1, with req_ready = 0. rsp_valid = 1 from E1 to E2, with the full 2*WIDTH data. The next acceptance is possible at E2, giving a throughput of one double per 2 cycles.
- rsp_valid is never high for more than one cycle per request. There is no backpressure on responses.
- Reset mid-operation: rst low at any time (including BEAT2 or INIT) immediately forces reset values. A partially written double leaves beat 1 committed, and INIT then clears it. No rsp_valid is produced for the aborted request.
- The request inputs are ignored when req_ready = 0.

## Test plan
- Reset and clear, bench ADDR_W=4, WIDTH=16, CLEAR_VAL=16'hA5A5: release rst. Expect init_done rising exactly 16 cycles later and req_ready = 0 until then. Single reads of addresses 0..15 all return 32'h0000A5A5.
- Single write 16'h1234 to addr 3, then read addr 3 in the next cycle. Expect the read response rsp_rdata = 32'h00001234, with one rsp_valid pulse per request.
- Double write 32'hDEADBEEF to addr 6. Expect req_ready = 0 for one cycle. A double read of addr 6 returns 32'hDEADBEEF; single reads return 16'hBEEF at addr 6 and 16'hDEAD at addr 7.
- Wrap: double write 32'h11112222 to addr 15. Expect mem[15] = 16'h2222 and mem[0] = 16'h1111. A double read of addr 15 returns 32'h11112222.
- Reset mid-double: accept a double write of 32'hCAFEF00D to addr 2, then assert rst during BEAT2. Expect outputs at reset values immediately and no rsp_valid. After INIT completes, addrs 2 and 3 read CLEAR_VAL.
- Hold req_valid = 1 with a double request pending and a second request queued. Expect exactly 1 acceptance per 2 cycles and an rsp_valid count equal to the acceptance count.
